// File: rtl/rv_bpu_pkg.sv
// Shared encodings for the branch prediction unit: control-flow kinds,
// 2-bit counter states, default sizing and the saturating counter step.
package rv_bpu_pkg;

  typedef enum logic [1:0] {
    BPU_NONE = 2'b00,
    BPU_BR   = 2'b01,
    BPU_JAL  = 2'b10,
    BPU_JALR = 2'b11
  } bpu_kind_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_RST = CTR_WNT;

  localparam int XLEN_D    = 64;
  localparam int BHT_IDX_D = 6;
  localparam int BTB_IDX_D = 4;
  localparam int HIST_W_D  = 6;
  localparam int CNT_W_D   = 32;

  // Saturates at both ends; never wraps.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/rv_bpu_if.sv
// Fetch-side lookup, execute-side resolution and statistics of the branch
// predictor; master = core pipeline, slave = predictor.
interface rv_bpu_if #(
  parameter int XLEN   = 64,
  parameter int HIST_W = 6,
  parameter int CNT_W  = 32
);
  logic [XLEN-1:0]   if_pc_i;
  logic              if_pred_taken_o;
  logic [XLEN-1:0]   if_pred_target_o;
  logic [HIST_W-1:0] if_ghr_o;
  logic              ex_valid_i;
  logic [XLEN-1:0]   ex_pc_i;
  logic [1:0]        ex_kind_i;
  logic              ex_taken_i;
  logic [XLEN-1:0]   ex_target_i;
  logic              ex_pred_taken_i;
  logic [XLEN-1:0]   ex_pred_target_i;
  logic [HIST_W-1:0] ex_ghr_i;
  logic              mispredict_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic [CNT_W-1:0]  stat_br_o;
  logic [CNT_W-1:0]  stat_miss_o;

  modport master (
    output if_pc_i, ex_valid_i, ex_pc_i, ex_kind_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i, ex_ghr_i,
    input  if_pred_taken_o, if_pred_target_o, if_ghr_o, mispredict_o,
           redirect_pc_o, stat_br_o, stat_miss_o
  );

  modport slave (
    input  if_pc_i, ex_valid_i, ex_pc_i, ex_kind_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i, ex_ghr_i,
    output if_pred_taken_o, if_pred_target_o, if_ghr_o, mispredict_o,
           redirect_pc_o, stat_br_o, stat_miss_o
  );
endinterface

// File: rtl/rv_bpu_btb.sv
// Direct-mapped branch target buffer: combinational read port, one write
// port; only the valid bits are cleared by reset.
module rv_bpu_btb
  import rv_bpu_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int BTB_IDX = BTB_IDX_D
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [BTB_IDX-1:0]        i_rd_idx,
  input  logic [XLEN-BTB_IDX-3:0]   i_rd_tag,
  output logic                      o_rd_hit,
  output logic [1:0]                o_rd_kind,
  output logic [XLEN-1:0]           o_rd_tgt,
  input  logic                      i_wr_en,
  input  logic [BTB_IDX-1:0]        i_wr_idx,
  input  logic [XLEN-BTB_IDX-3:0]   i_wr_tag,
  input  logic [1:0]                i_wr_kind,
  input  logic [XLEN-1:0]           i_wr_tgt
);
  localparam int N     = 1 << BTB_IDX;
  localparam int TAG_W = XLEN - BTB_IDX - 2;

  logic [N-1:0]     r_valid;
  logic [TAG_W-1:0] r_tag  [N];
  logic [XLEN-1:0]  r_tgt  [N];
  logic [1:0]       r_kind [N];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_tgt[i_wr_idx]  <= i_wr_tgt;
      r_kind[i_wr_idx] <= i_wr_kind;
    end
  end

  assign o_rd_hit  = r_valid[i_rd_idx] & (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_kind = r_kind[i_rd_idx];
  assign o_rd_tgt  = r_tgt[i_rd_idx];

endmodule

// File: rtl/rv_bpu.sv
// Branch prediction unit: BHT + BTB lookup at fetch, resolution/update at execute.
// Define RV_BPU_GSHARE_EN to hash the BHT index with a global history register.
module rv_bpu
  import rv_bpu_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int BHT_IDX = BHT_IDX_D,
  parameter int BTB_IDX = BTB_IDX_D,
  parameter int HIST_W  = HIST_W_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic    clk,
  input  logic    rstn,
  rv_bpu_if.slave bus
);
  localparam int BHT_N = 1 << BHT_IDX;

  logic [1:0]         r_bht [BHT_N];
  logic [CNT_W-1:0]   r_stat_br;
  logic [CNT_W-1:0]   r_stat_miss;
  logic [BHT_IDX-1:0] w_lk_idx;
  logic [BHT_IDX-1:0] w_up_idx;
  logic               w_hit;
  logic [1:0]         w_kind;
  logic [XLEN-1:0]    w_tgt;
  logic               w_pred_taken;
  logic               w_upd;
  logic               w_is_br;
  logic               w_mis;
  logic [XLEN-1:0]    w_if_pc4;
  logic [XLEN-1:0]    w_ex_pc4;

  assign w_if_pc4 = bus.if_pc_i + XLEN'(4);
  assign w_ex_pc4 = bus.ex_pc_i + XLEN'(4);
  assign w_upd    = bus.ex_valid_i & (bus.ex_kind_i != BPU_NONE);
  assign w_is_br  = (bus.ex_kind_i == BPU_BR);

`ifdef RV_BPU_GSHARE_EN
  logic [HIST_W-1:0] r_ghr;

  assign w_lk_idx     = bus.if_pc_i[BHT_IDX+1:2] ^ BHT_IDX'(r_ghr);
  assign w_up_idx     = bus.ex_pc_i[BHT_IDX+1:2] ^ BHT_IDX'(bus.ex_ghr_i);
  assign bus.if_ghr_o = r_ghr;

  // A mispredict rebuilds history from the snapshot the resolving instr was predicted with.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ghr <= '0;
    end else if (w_upd && w_mis) begin
      r_ghr <= HIST_W'({bus.ex_ghr_i, bus.ex_taken_i});
    end else if (w_upd && w_is_br) begin
      r_ghr <= HIST_W'({r_ghr, bus.ex_taken_i});
    end
  end
`else
  logic w_unused_ghr;

  assign w_lk_idx     = bus.if_pc_i[BHT_IDX+1:2];
  assign w_up_idx     = bus.ex_pc_i[BHT_IDX+1:2];
  assign bus.if_ghr_o = '0;
  assign w_unused_ghr = ^bus.ex_ghr_i;
`endif

  rv_bpu_btb #(.XLEN(XLEN), .BTB_IDX(BTB_IDX)) u_btb (
    .clk       (clk),
    .rstn      (rstn),
    .i_rd_idx  (bus.if_pc_i[BTB_IDX+1:2]),
    .i_rd_tag  (bus.if_pc_i[XLEN-1:BTB_IDX+2]),
    .o_rd_hit  (w_hit),
    .o_rd_kind (w_kind),
    .o_rd_tgt  (w_tgt),
    .i_wr_en   (w_upd & bus.ex_taken_i),
    .i_wr_idx  (bus.ex_pc_i[BTB_IDX+1:2]),
    .i_wr_tag  (bus.ex_pc_i[XLEN-1:BTB_IDX+2]),
    .i_wr_kind (bus.ex_kind_i),
    .i_wr_tgt  (bus.ex_target_i)
  );

  assign w_pred_taken         = w_hit & ((w_kind != BPU_BR) | r_bht[w_lk_idx][1]);
  assign bus.if_pred_taken_o  = w_pred_taken;
  assign bus.if_pred_target_o = w_pred_taken ? w_tgt : w_if_pc4;

  assign w_mis = w_upd & ((bus.ex_taken_i != bus.ex_pred_taken_i) |
                          (bus.ex_taken_i & (bus.ex_target_i != bus.ex_pred_target_i)));
  assign bus.mispredict_o  = w_mis;
  assign bus.redirect_pc_o = bus.ex_taken_i ? bus.ex_target_i : w_ex_pc4;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= CTR_RST;
    end else if (w_upd && w_is_br) begin
      r_bht[w_up_idx] <= ctr_next(r_bht[w_up_idx], bus.ex_taken_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_br   <= '0;
      r_stat_miss <= '0;
    end else if (w_upd) begin
      r_stat_br   <= r_stat_br + CNT_W'(1);
      r_stat_miss <= r_stat_miss + CNT_W'(w_mis);
    end
  end

  assign bus.stat_br_o   = r_stat_br;
  assign bus.stat_miss_o = r_stat_miss;

endmodule
